// File: rtl/compressor_seq_pkg.sv
// Shared defaults, beat-index width helper and state type for the
// compressor load sequencer and its frame buffer.
package compressor_seq_pkg;

  localparam int DEF_ROWS  = 15;
  localparam int DEF_COLS  = 15;
  localparam int DEF_OUT_W = 19;

  // Bits needed to index one slice of a COLS-deep frame (never zero).
  function automatic int beat_width(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  localparam int BEAT_W = beat_width(DEF_COLS);

  typedef enum logic [1:0] {
    FILL,
    BURST,
    WAIT,
    RESULT
  } seq_state_e;

endpackage

// File: rtl/compressor_frame_buffer.sv
// COLS x ROWS slice store for one operand frame: synchronous write port,
// combinational read port.
module compressor_frame_buffer
  import compressor_seq_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int IDX_W = BEAT_W
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [ROWS-1:0]  wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [ROWS-1:0]  rd_data_o
);

  logic [ROWS-1:0] mem_q [COLS];

  // NOTE: the array has no reset; a frame is only ever burst after every
  // entry of it has been written, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/compressor_load_sequencer.sv
// Collects one operand frame from a valid/ready stream, bursts it into the
// free-running source shift registers, then captures and hands off the result.
module compressor_load_sequencer
  import compressor_seq_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROWS-1:0]  in_slice,
  input  logic             in_last,
  output logic [ROWS-1:0]  ser_out,
  input  logic [OUT_W-1:0] dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             frame_err,
  output logic             busy
);

  localparam int IDX_W  = beat_width(COLS);
  localparam int WAIT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(COLS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(LATENCY);

  seq_state_e        state_q;
  logic [IDX_W-1:0]  beat_q;
  logic [WAIT_W-1:0] wait_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [ROWS-1:0]   ser_out_q;
  logic              frame_err_q;
  logic              busy_q;

  logic              accept;
  logic              last_beat;
  logic [IDX_W-1:0]  rd_idx;
  logic [ROWS-1:0]   rd_data;

  assign accept    = in_valid && in_ready_q;
  assign last_beat = (beat_q == LAST_BEAT);

  // NOTE: combinational logic uses blocking '=' and assigns a default first,
  // so every path drives rd_idx and no latch is inferred.
  always_comb begin
    rd_idx = '0;
    if (state_q == BURST && !last_beat) rd_idx = beat_q + 1'b1;
  end

  compressor_frame_buffer #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_frame_buffer (
    .clk       (clk),
    .we_i      (accept),
    .wr_idx_i  (beat_q),
    .wr_data_i (in_slice),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      beat_q      <= '0;
      wait_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ser_out_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (in_last && last_beat) begin
              // Slice 0 goes out on the very next cycle.
              state_q    <= BURST;
              beat_q     <= '0;
              ser_out_q  <= rd_data;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else if (in_last || last_beat) begin
              frame_err_q <= 1'b1;
              beat_q      <= '0;
              busy_q      <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
              busy_q <= 1'b1;
            end
          end
        end
        BURST: begin
          if (last_beat) begin
            state_q   <= WAIT;
            ser_out_q <= '0;
            wait_q    <= '0;
          end else begin
            beat_q    <= beat_q + 1'b1;
            ser_out_q <= rd_data;
          end
        end
        WAIT: begin
          if (wait_q == LAST_WAIT) begin
            state_q     <= RESULT;
            out_data_q  <= dst;
            out_valid_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RESULT: begin
          if (out_ready) begin
            state_q     <= FILL;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ser_out   = ser_out_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/compressor_load_sequencer.md
# compressor_load_sequencer

Sequencer that owns the serial load path of the square-compressor test harness: it collects one operand frame (COLS slices, each carrying one bit per source row) from an upstream valid/ready stream, bursts it into the free-running source shift registers on consecutive cycles, then captures the compressor's OUT_W-bit result and hands it downstream. It sits between the stimulus stream and the shift-register/compressor pair. It exists because those shift registers shift on every clock with no enable, so upstream stalls must never reach them mid-frame.

## Interface
- ROWS, 15, number of source rows (serial inputs src0_..src14_)
- COLS, 15, shift-register depth; slices per frame
- OUT_W, 19, result width (dst0..dst18 concatenated, dst0 = bit 0)
- LATENCY, 0, compressor pipeline depth in cycles (0 = purely combinational)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  slice valid
- in_ready  out  1  slice accepted when in_valid && in_ready
- in_slice  in  ROWS  bit j is the next serial bit for row j
- in_last  in  1  marks final slice of a frame
- ser_out  out  ROWS  bit j drives srcj_ of the shift register
- dst  in  OUT_W  compressor result
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  captured result
- frame_err  out  1  one-cycle pulse on in_last framing error
- busy  out  1  high in any state other than FILL with beat count 0

## Operation
- States: FILL, BURST, WAIT, RESULT. Reset state FILL, beat count 0.
- FILL: in_ready=1. Each accepted slice is stored at buffer index = beat count, and the count increments. Framing is checked on every accepted slice:
  - in_last on beat COLS-1: go to BURST.
  - in_last on any other beat, or in_last missing on beat COLS-1: pulse frame_err next cycle, discard the frame, and return the count to 0 (stay in FILL).
- BURST: in_ready=0. ser_out = buffer[k] for k = 0..COLS-1 on COLS consecutive cycles, never interrupted. Slice 0 ends at shift-register bit COLS-1 and slice COLS-1 at bit 0. After the last slice, go to WAIT.
- WAIT: ser_out = 0. Stays LATENCY+1 cycles. On the final edge of WAIT, dst is sampled into out_data. That edge is exactly LATENCY+1 edges after the edge that shifted slice COLS-1. Then go to RESULT.
- RESULT: out_valid=1, out_data stable. On out_valid && out_ready, go to FILL with count 0.
- ser_out is 0 in every state except BURST.
- Frames never overlap: no slice is accepted during BURST, WAIT or RESULT.

## Timing
- Reset values, asynchronous on rst_n low: in_ready=0 while rst_n is low and 1 from the first cycle after release; out_valid=0, out_data=0, ser_out=0, frame_err=0, busy=0. The buffer is not cleared.
- Reset mid-operation (any state): abort immediately, drop the partial or complete frame and any pending result.
- Latency from the accepting edge of the in_last slice to out_valid rising: COLS+LATENCY+1 cycles.
- Minimum frame period, with no backpressure on either side: 2·COLS+LATENCY+2 cycles.
- frame_err is exactly one cycle wide. Back-to-back errors give back-to-back pulses.
- in_valid deasserted mid-FILL: the count holds with no timeout. ser_out is still 0, so the shift registers stay clean.
- out_ready held low: the sequencer stays in RESULT indefinitely. dst changes during this time are ignored.

## Structure
- Shared package compressor_seq_pkg: ROWS/COLS/OUT_W defaults, the state enum (FILL, BURST, WAIT, RESULT), and a beat-count width constant = clog2(COLS).
- Sub-module compressor_frame_buffer: COLS×ROWS register array with a write port (index, data, we) and a read port (index → data). The FSM, beat counter and wait counter live in the top module.

## Test plan
- Reset, then frame of COLS slices all 15'h7FFF, in_last on beat 14, out_ready=1, LATENCY=0 → out_valid rises 16 cycles after the last accept. out_data equals the golden compressor sum of fifteen 15'h7FFF rows (sum of fifteen 15'h7FFF operands = 19'h77FF1).
- Slice k = one-hot(k), LATENCY=2 → ser_out shows one-hot(0..14) on 15 consecutive cycles. Result is captured 3 edges after the final shift and matches the model.
- in_last on beat 5 → frame_err pulses once. No ser_out activity. A following good frame completes normally.
- Frame with no in_last on beat 14 → frame_err pulse, frame dropped, beat count returns to 0.
- out_ready=0 for 20 cycles in RESULT → out_data stable, in_ready=0, ser_out=0 throughout. The result is accepted on the first out_ready=1.
- rst_n low mid-BURST at k=7 → outputs reach reset values within the same cycle. The next frame's result is unaffected by the aborted frame.
